// File: rtl/cla_byte_serial_ctrl_if.sv
// Operand/result handshake bundle for the byte-serial CLA sequencer.
// The slave modport is the sequencer; the master modport is its producer/consumer.
interface cla_byte_serial_ctrl_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/cla_byte_serial_ctrl.sv
// W-bit add/subtract built from one 8-bit carry-lookahead adder reused over NBYTES passes,
// least-significant byte first, with a registered inter-byte carry.
module cla_byte_serial_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input logic                   clk,
    input logic                   rst,
    cla_byte_serial_ctrl_if.slave bus
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned CntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            carry_q;
    logic [W-1:0]    op_a_q;
    logic [W-1:0]    op_b_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic            valid_q;
    logic            busy_q;

    logic            in_ready;
    logic            accept;
    logic [CntW+2:0] byte_base;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      gen;
    logic [7:0]      prop;
    logic [8:0]      carry;
    logic [7:0]      byte_sum;
    logic            byte_cout;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StRun:   in_ready = 1'b0;
            StDone:  in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = bus.in_valid & in_ready;
    assign byte_base = {cnt_q, 3'b000};
    assign a_byte    = op_a_q[byte_base +: 8];
    assign b_byte    = op_b_q[byte_base +: 8];

    // 8-bit CLA: every carry is a flat sum of generate terms gated by the propagate chain.
    always_comb begin
        logic pp;
        gen      = a_byte & b_byte;
        prop     = a_byte ^ b_byte;
        carry    = '0;
        carry[0] = carry_q;
        pp       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i];
            pp         = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (pp & gen[j]);
                pp         = pp & prop[j];
            end
            carry[i+1] = carry[i+1] | (pp & carry_q);
        end
        byte_sum  = prop ^ carry[7:0];
        byte_cout = carry[8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the DONE hand-off that overlaps consume with accept.
            state_q <= StRun;
            cnt_q   <= '0;
            op_a_q  <= bus.in_a;
            op_b_q  <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                StRun: begin
                    sum_q[byte_base +: 8] <= byte_sum;
                    carry_q               <= byte_cout;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cout_q  <= byte_cout;
                        ovf_q   <= (op_a_q[W-1] == op_b_q[W-1]) & (byte_sum[7] != op_a_q[W-1]);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cla_byte_serial_ctrl.sv
// Directed bench for cla_byte_serial_ctrl: literal expectations per operation plus a
// transaction-level model compared against the DUT on every falling edge.
module tb_cla_byte_serial_ctrl;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cla_byte_serial_ctrl_if #(.NBYTES(NB)) bus ();

    cla_byte_serial_ctrl #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 computing, 2 holding a result.
    int           m_phase;
    int           m_left;
    logic         m_valid;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;

    always @(posedge clk or posedge rst) begin
        logic         ready_now;
        logic [W-1:0] beff;
        logic [W:0]   full;
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
            m_valid = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            ready_now = (m_phase == 0) || (m_phase == 2 && bus.out_ready);
            if (m_phase == 2 && bus.out_ready) begin
                m_phase = 0;
                m_valid = 1'b0;
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_valid = 1'b1;
                    m_sum   = p_sum;
                    m_cout  = p_cout;
                    m_ovf   = p_ovf;
                end
            end
            if (bus.in_valid && ready_now) begin
                beff    = bus.in_sub ? ~bus.in_b : bus.in_b;
                full    = {1'b0, bus.in_a} + {1'b0, beff} + (W+1)'(bus.in_sub ? 1'b1 : bus.in_cin);
                p_sum   = full[W-1:0];
                p_cout  = full[W];
                p_ovf   = (bus.in_a[W-1] == beff[W-1]) && (full[W-1] != bus.in_a[W-1]);
                m_phase = 1;
                m_left  = NB;
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("cmp_in_ready", 64'(bus.in_ready),
                64'((m_phase == 0) || (m_phase == 2 && bus.out_ready)));
            chk("cmp_busy", 64'(bus.busy), 64'(m_phase == 1));
            if (m_valid) begin
                chk("cmp_out_sum", 64'(bus.out_sum), 64'(m_sum));
                chk("cmp_out_cout", 64'(bus.out_cout), 64'(m_cout));
                chk("cmp_out_ovf", 64'(bus.out_ovf), 64'(m_ovf));
            end
        end
    end

    // Called at #1 after an edge with in_ready high; returns #1 after the accept edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_b     = 32'hCAFE_F00D;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] esum,
                            input logic ecout, input logic eovf);
        int lat;
        do_op(a, b, cin, sub);
        wait_valid(lat);
        chk({name, "_latency"}, 64'(lat), 64'(NB));
        chk({name, "_sum"}, 64'(bus.out_sum), 64'(esum));
        chk({name, "_cout"}, 64'(bus.out_cout), 64'(ecout));
        chk({name, "_ovf"}, 64'(bus.out_ovf), 64'(eovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op_check("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        op_check("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        op_check("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op_check("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op_check("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
        op_check("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Backpressure, then consume and accept at the same edge.
        bus.out_ready = 1'b0;
        do_op(32'd3, 32'd4, 1'b0, 1'b0);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'(NB));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_sum", 64'(bus.out_sum), 64'd7);
        end
        bus.in_a      = 32'd1;
        bus.in_b      = 32'd2;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready_comb", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("b2b_valid_drop", 64'(bus.out_valid), 64'd0);
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        wait_valid(lat);
        chk("b2b_latency", 64'(lat), 64'(NB));
        chk("b2b_sum", 64'(bus.out_sum), 64'd3);
        @(posedge clk);
        #1;

        // Abort while the third byte is being added.
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_out_sum", 64'(bus.out_sum), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        op_check("after_abort", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
